// File: rtl/mastermind_pkg.sv
// Shared types and width helpers for the Mastermind scorer.
package mastermind_pkg;

    typedef enum logic [1:0] {IDLE, RED, WHITE, DONE} state_e;

    function automatic int unsigned cnt_width(input int unsigned n_pegs);
        return $clog2(n_pegs + 1);
    endfunction

    function automatic int unsigned gc_width(input int unsigned max_guesses);
        return $clog2(max_guesses + 1);
    endfunction

    // One counter walks both the peg pass and the colour pass, so it must cover the wider one.
    function automatic int unsigned idx_width(input int unsigned n_pegs, input int unsigned color_w);
        int unsigned peg_w;
        peg_w = (n_pegs > 1) ? $clog2(n_pegs) : 1;
        return (peg_w > color_w) ? peg_w : color_w;
    endfunction

endpackage

// File: rtl/mm_color_hist.sv
// Per-colour occurrence counters for the unmatched code and guess pegs, read back as a
// per-colour minimum.
module mm_color_hist #(
    parameter int unsigned  COLOR_W    = 3,
    parameter int unsigned  CNT_W      = 3,
    localparam int unsigned NUM_COLORS = 2 ** COLOR_W
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clr_i,
    input  logic               code_inc_i,
    input  logic [COLOR_W-1:0] code_col_i,
    input  logic               guess_inc_i,
    input  logic [COLOR_W-1:0] guess_col_i,
    input  logic [COLOR_W-1:0] rd_idx_i,
    output logic [CNT_W-1:0]   min_o
);

    logic [CNT_W-1:0] code_cnt_q  [NUM_COLORS];
    logic [CNT_W-1:0] code_cnt_d  [NUM_COLORS];
    logic [CNT_W-1:0] guess_cnt_q [NUM_COLORS];
    logic [CNT_W-1:0] guess_cnt_d [NUM_COLORS];

    always_comb begin
        for (int c = 0; c < NUM_COLORS; c++) begin
            code_cnt_d[c]  = code_cnt_q[c];
            guess_cnt_d[c] = guess_cnt_q[c];
        end
        if (clr_i) begin
            for (int c = 0; c < NUM_COLORS; c++) begin
                code_cnt_d[c]  = '0;
                guess_cnt_d[c] = '0;
            end
        end else begin
            if (code_inc_i) begin
                code_cnt_d[code_col_i] = code_cnt_q[code_col_i] + CNT_W'(1);
            end
            if (guess_inc_i) begin
                guess_cnt_d[guess_col_i] = guess_cnt_q[guess_col_i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int c = 0; c < NUM_COLORS; c++) begin
                code_cnt_q[c]  <= '0;
                guess_cnt_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_COLORS; c++) begin
                code_cnt_q[c]  <= code_cnt_d[c];
                guess_cnt_q[c] <= guess_cnt_d[c];
            end
        end
    end

    assign min_o = (code_cnt_q[rd_idx_i] < guess_cnt_q[rd_idx_i]) ? code_cnt_q[rd_idx_i]
                                                                  : guess_cnt_q[rd_idx_i];

endmodule

// File: rtl/mastermind_scorer.sv
// Sequential Mastermind scorer: exact-match pass over pegs, then a histogram pass over colours.
// Define MM_GUESS_LIMIT_EN to end the game with lose after MAX_GUESSES non-winning guesses.
module mastermind_scorer
    import mastermind_pkg::*;
#(
    parameter int unsigned  N_PEGS      = 4,
    parameter int unsigned  COLOR_W     = 3,
    parameter int unsigned  MAX_GUESSES = 8,
    localparam int unsigned NUM_COLORS  = 2 ** COLOR_W,
    localparam int unsigned CNT_W       = cnt_width(N_PEGS),
    localparam int unsigned GC_W        = gc_width(MAX_GUESSES),
    localparam int unsigned IDX_W       = idx_width(N_PEGS, COLOR_W)
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        new_game,
    input  logic                        code_load,
    input  logic [N_PEGS*COLOR_W-1:0]   code_in,
    input  logic                        start,
    input  logic [N_PEGS*COLOR_W-1:0]   guess_in,
    output logic                        ready,
    output logic                        result_valid,
    output logic [CNT_W-1:0]            red,
    output logic [CNT_W-1:0]            white,
    output logic [GC_W-1:0]             guess_count,
    output logic                        win,
    output logic                        lose
);

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [N_PEGS*COLOR_W-1:0]   code_q, code_d, guess_q, guess_d;
    logic [CNT_W-1:0]            red_acc_q, red_acc_d, white_acc_q, white_acc_d;
    logic [CNT_W-1:0]            red_q, red_d, white_q, white_d;
    logic [GC_W-1:0]             gc_q, gc_d;
    logic                        win_q, win_d, lose_q, lose_d, rv_q, rv_d;
    logic                        accept, hist_clr, hist_inc;
    logic [COLOR_W-1:0]          code_peg, guess_peg;
    logic [CNT_W-1:0]            hist_min;

    assign ready  = (state_q == IDLE) && !win_q && !lose_q;
    assign accept = start && ready && !new_game;

    always_comb begin
        code_peg  = '0;
        guess_peg = '0;
        for (int p = 0; p < N_PEGS; p++) begin
            if (idx_q == IDX_W'(p)) begin
                code_peg  = code_q[p*COLOR_W +: COLOR_W];
                guess_peg = guess_q[p*COLOR_W +: COLOR_W];
            end
        end
    end

    mm_color_hist #(
        .COLOR_W (COLOR_W),
        .CNT_W   (CNT_W)
    ) u_hist (
        .clk         (clk),
        .resetn      (resetn),
        .clr_i       (hist_clr),
        .code_inc_i  (hist_inc),
        .code_col_i  (code_peg),
        .guess_inc_i (hist_inc),
        .guess_col_i (guess_peg),
        .rd_idx_i    (idx_q[COLOR_W-1:0]),
        .min_o       (hist_min)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        code_d      = code_q;
        guess_d     = guess_q;
        red_acc_d   = red_acc_q;
        white_acc_d = white_acc_q;
        red_d       = red_q;
        white_d     = white_q;
        gc_d        = gc_q;
        win_d       = win_q;
        lose_d      = lose_q;
        rv_d        = 1'b0;
        hist_clr    = 1'b0;
        hist_inc    = 1'b0;

        if (new_game) begin
            state_d = IDLE;
            idx_d   = '0;
            red_d   = '0;
            white_d = '0;
            gc_d    = '0;
            win_d   = 1'b0;
            lose_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (code_load) begin
                        code_d = code_in;
                    end
                    if (accept) begin
                        guess_d     = guess_in;
                        hist_clr    = 1'b1;
                        red_acc_d   = '0;
                        white_acc_d = '0;
                        idx_d       = '0;
                        state_d     = RED;
                    end
                end
                RED: begin
                    if (code_peg == guess_peg) begin
                        red_acc_d = red_acc_q + CNT_W'(1);
                    end else begin
                        hist_inc = 1'b1;
                    end
                    if (idx_q == IDX_W'(N_PEGS - 1)) begin
                        idx_d   = '0;
                        state_d = WHITE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                WHITE: begin
                    white_acc_d = white_acc_q + hist_min;
                    if (idx_q == IDX_W'(NUM_COLORS - 1)) begin
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    red_d   = red_acc_q;
                    white_d = white_acc_q;
                    rv_d    = 1'b1;
                    if (gc_q != {GC_W{1'b1}}) begin
                        gc_d = gc_q + GC_W'(1);
                    end
                    if (red_acc_q == CNT_W'(N_PEGS)) begin
                        win_d = 1'b1;
                    end
`ifdef MM_GUESS_LIMIT_EN
                    else if (gc_d == GC_W'(MAX_GUESSES)) begin
                        lose_d = 1'b1;
                    end
`endif
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            code_q      <= '0;
            guess_q     <= '0;
            red_acc_q   <= '0;
            white_acc_q <= '0;
            red_q       <= '0;
            white_q     <= '0;
            gc_q        <= '0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
            rv_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            code_q      <= code_d;
            guess_q     <= guess_d;
            red_acc_q   <= red_acc_d;
            white_acc_q <= white_acc_d;
            red_q       <= red_d;
            white_q     <= white_d;
            gc_q        <= gc_d;
            win_q       <= win_d;
            lose_q      <= lose_d;
            rv_q        <= rv_d;
        end
    end

    assign result_valid = rv_q;
    assign red          = red_q;
    assign white        = white_q;
    assign guess_count  = gc_q;
    assign win          = win_q;
    assign lose         = lose_q;

endmodule

// File: tb/tb_mastermind_scorer.sv
// Bench for mastermind_scorer (4 pegs, 3-bit colours): directed cases plus random traffic
// checked each cycle against a colour-counting reference model.
module tb_mastermind_scorer;

    localparam int NP = 4;
    localparam int NC = 8;
    localparam int MAXG = 8;
    localparam int GC_SAT = 15;
    localparam int LAT = NP + NC + 1;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        new_game = 1'b0;
    logic        code_load = 1'b0;
    logic        start = 1'b0;
    logic [11:0] code_in = '0;
    logic [11:0] guess_in = '0;
    logic        ready, result_valid, win, lose;
    logic [2:0]  red, white;
    logic [3:0]  guess_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mastermind_scorer dut (
        .clk          (clk),
        .resetn       (resetn),
        .new_game     (new_game),
        .code_load    (code_load),
        .code_in      (code_in),
        .start        (start),
        .guess_in     (guess_in),
        .ready        (ready),
        .result_valid (result_valid),
        .red          (red),
        .white        (white),
        .guess_count  (guess_count),
        .win          (win),
        .lose         (lose)
    );

    // Reference model: time-to-result countdown plus scores from colour counts.
    int          m_cd = 0, m_red = 0, m_white = 0, m_gc = 0, p_red = 0, p_white = 0;
    bit          m_win = 0, m_lose = 0, m_rv = 0;
    logic [11:0] m_code = '0;

    function automatic void score(input logic [11:0] c, input logic [11:0] g,
                                  output int r, output int w);
        int hc[NC];
        int hg[NC];
        for (int k = 0; k < NC; k++) begin
            hc[k] = 0;
            hg[k] = 0;
        end
        r = 0;
        w = 0;
        for (int i = 0; i < NP; i++) begin
            if (c[i*3 +: 3] == g[i*3 +: 3]) r++;
            hc[c[i*3 +: 3]]++;
            hg[g[i*3 +: 3]]++;
        end
        for (int k = 0; k < NC; k++) w += (hc[k] < hg[k]) ? hc[k] : hg[k];
        w -= r;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_cd = 0; m_code = '0; m_red = 0; m_white = 0; m_gc = 0;
            m_win = 0; m_lose = 0; m_rv = 0;
        end else if (new_game) begin
            m_cd = 0; m_red = 0; m_white = 0; m_gc = 0; m_win = 0; m_lose = 0; m_rv = 0;
        end else begin
            m_rv = 0;
            if (m_cd > 0) begin
                m_cd--;
                if (m_cd == 0) begin
                    m_red = p_red;
                    m_white = p_white;
                    m_rv = 1;
                    if (m_gc < GC_SAT) m_gc++;
                    if (p_red == NP) m_win = 1;
`ifdef MM_GUESS_LIMIT_EN
                    else if (m_gc == MAXG) m_lose = 1;
`endif
                end
            end else begin
                if (code_load) m_code = code_in;
                if (start && !m_win && !m_lose) begin
                    score(m_code, guess_in, p_red, p_white);
                    m_cd = LAT;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("ready", 32'(ready), 32'(m_cd == 0 && !m_win && !m_lose));
        chk("result_valid", 32'(result_valid), 32'(m_rv));
        chk("red", 32'(red), 32'(m_red));
        chk("white", 32'(white), 32'(m_white));
        chk("guess_count", 32'(guess_count), 32'(m_gc));
        chk("win", 32'(win), 32'(m_win));
        chk("lose", 32'(lose), 32'(m_lose));
    end

    function automatic logic [11:0] pack(input int p0, input int p1, input int p2, input int p3);
        return {3'(p3), 3'(p2), 3'(p1), 3'(p0)};
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [11:0] c);
        code_load = 1'b1;
        code_in = c;
        cyc(1);
        code_load = 1'b0;
    endtask

    task automatic ngame();
        new_game = 1'b1;
        cyc(1);
        new_game = 1'b0;
    endtask

    task automatic start_guess(input logic [11:0] g);
        start = 1'b1;
        guess_in = g;
        cyc(1);
        start = 1'b0;
    endtask

    // Edges since accept already elapsed are passed in; result must appear after edge LAT.
    task automatic wait_result(input int done);
        int lat = -1;
        for (int k = done + 1; k <= 40; k++) begin
            cyc(1);
            if (result_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk("latency", 32'(lat), 32'(LAT));
    endtask

    task automatic play(input logic [11:0] g);
        start_guess(g);
        wait_result(0);
    endtask

    logic [11:0] last_code = '0;

    function automatic logic [11:0] rand_code(input bit narrow);
        logic [11:0] v;
        for (int i = 0; i < NP; i++) begin
            v[i*3 +: 3] = narrow ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
        end
        return v;
    endfunction

    initial begin
        cyc(3);
        resetn = 1'b1;
        cyc(1);
        chk("reset ready", 32'(ready), 1);
        chk("reset red", 32'(red), 0);
        chk("reset guess_count", 32'(guess_count), 0);

        // Exact match on first guess wins and closes the game.
        load(pack(1, 2, 3, 4));
        play(pack(1, 2, 3, 4));
        chk("t1 red", 32'(red), 4);
        chk("t1 white", 32'(white), 0);
        chk("t1 win", 32'(win), 1);
        chk("t1 gc", 32'(guess_count), 1);
        chk("t1 ready", 32'(ready), 0);

        ngame();
        load(pack(1, 1, 2, 2));
        play(pack(2, 2, 1, 1));
        chk("t2 red", 32'(red), 0);
        chk("t2 white", 32'(white), 4);
        chk("t2 win", 32'(win), 0);
        chk("t2 ready", 32'(ready), 1);

        ngame();
        load(pack(1, 1, 2, 3));
        play(pack(1, 2, 1, 1));
        chk("t3a red", 32'(red), 1);
        chk("t3a white", 32'(white), 2);
        play(pack(5, 6, 7, 0));
        chk("t3b red", 32'(red), 0);
        chk("t3b white", 32'(white), 0);
        chk("t3b gc", 32'(guess_count), 2);

        ngame();
        load(pack(7, 7, 7, 7));
        for (int i = 0; i < MAXG; i++) play(pack(0, 0, 0, 0));
`ifdef MM_GUESS_LIMIT_EN
        chk("t4 lose", 32'(lose), 1);
        chk("t4 ready", 32'(ready), 0);
        start_guess(pack(0, 0, 0, 0));
        cyc(20);
        chk("t4 ninth ignored gc", 32'(guess_count), MAXG);
`else
        play(pack(0, 0, 0, 0));
        chk("t4 ninth scored gc", 32'(guess_count), MAXG + 1);
        chk("t4 lose", 32'(lose), 0);
`endif

        // new_game during the colour pass aborts the score.
        ngame();
        play(pack(1, 1, 1, 1));
        start_guess(pack(2, 2, 2, 2));
        cyc(6);
        ngame();
        chk("t5 abort ready", 32'(ready), 1);
        chk("t5 abort gc", 32'(guess_count), 0);
        cyc(20);
        chk("t5 abort no result gc", 32'(guess_count), 0);

        // Asynchronous reset while pegs are being compared.
        load(pack(1, 2, 3, 4));
        play(pack(1, 3, 3, 3));
        start_guess(pack(1, 2, 3, 4));
        cyc(2);
        resetn = 1'b0;
        #1;
        chk("t5 rst red", 32'(red), 0);
        chk("t5 rst white", 32'(white), 0);
        chk("t5 rst gc", 32'(guess_count), 0);
        chk("t5 rst rv", 32'(result_valid), 0);
        cyc(2);
        resetn = 1'b1;
        cyc(1);

        // Code load while scoring is ignored.
        load(pack(1, 2, 3, 4));
        start_guess(pack(1, 2, 3, 4));
        code_load = 1'b1;
        code_in = pack(5, 5, 5, 5);
        cyc(1);
        code_load = 1'b0;
        wait_result(1);
        chk("t6a red", 32'(red), 4);

        // Code load together with accept uses the new code.
        ngame();
        code_load = 1'b1;
        code_in = pack(3, 3, 3, 3);
        start_guess(pack(3, 3, 3, 3));
        code_load = 1'b0;
        wait_result(0);
        chk("t6b red", 32'(red), 4);
        chk("t6b white", 32'(white), 0);

        ngame();
        for (int i = 0; i < 3000; i++) begin
            new_game = ($urandom_range(0, 79) == 0) || ((m_win || m_lose) && $urandom_range(0, 3) == 0);
            code_load = ($urandom_range(0, 9) == 0);
            start = ($urandom_range(0, 2) == 0);
            code_in = rand_code(1'($urandom_range(0, 1)));
            if (code_load) last_code = code_in;
            guess_in = ($urandom_range(0, 5) == 0) ? last_code : rand_code(1'($urandom_range(0, 1)));
            cyc(1);
        end
        new_game = 1'b0;
        code_load = 1'b0;
        start = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
